// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register controller family.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam bit DIR_MSB = 1'b0;
    localparam bit DIR_LSB = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register; load has priority over shift.
module piso_shift_reg
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q
);

    localparam bit LSB_OUT = (LSB_FIRST != 0);

    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;

    // Output tap and shift direction both follow the bit order.
    if (LSB_OUT == DIR_LSB) begin : g_lsb
        assign q         = r_shreg[0];
        assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end else begin : g_msb
        assign q         = r_shreg[WIDTH-1];
        assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (load) begin
            r_shreg <= d;
        end else if (shift) begin
            r_shreg <= w_shifted;
        end
    end

endmodule

// File: rtl/shift_reg_ctrl.sv
// Serialises handshaked parallel words with a programmable inter-frame gap
// and a wrapping completed-frame counter.
module shift_reg_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned GAP       = 2,
    parameter int unsigned LSB_FIRST = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t             r_state;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               r_in_ready;
    logic               r_ser_valid;
    logic               r_frame_start;
    logic               r_busy;

    logic               w_accept;
    logic               w_shift;
    logic               w_last;
    logic               w_load;
    logic [WIDTH-1:0]   w_load_d;
    logic               w_q;

    assign w_accept = in_valid & r_in_ready;
    assign w_shift  = (r_state == S_SHIFT) & shift_en;
    assign w_last   = w_shift & (r_bit_cnt == BIT_LAST);

    // Clearing the register at frame end keeps ser_out low outside SHIFT.
    assign w_load   = w_accept | w_last;
    assign w_load_d = w_accept ? in_data : '0;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .shift (w_shift),
        .d     (w_load_d),
        .q     (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_in_ready    <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_state       <= S_SHIFT;
                        r_bit_cnt     <= '0;
                        r_in_ready    <= 1'b0;
                        r_ser_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (shift_en) begin
                        r_frame_start <= 1'b0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            r_bit_cnt   <= '0;
                            r_ser_valid <= 1'b0;
                            if (GAP == 0) begin
                                r_state    <= S_IDLE;
                                r_in_ready <= 1'b1;
                                r_busy     <= 1'b0;
                            end else begin
                                r_state   <= S_GAP;
                                r_gap_cnt <= '0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    // Gap is timed in clock cycles, independent of shift_en.
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign ser_out     = w_q;
    assign ser_valid   = r_ser_valid;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Scoreboard bench for shift_reg_ctrl: two configurations, randomized words
// and bit-rate enables, expected bit stream derived from each accepted word.
module tb_shift_reg_ctrl;

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int          G   = g;
        localparam int unsigned W   = 8;
        localparam int unsigned GP  = (g == 0) ? 2 : 0;
        localparam int unsigned LSB = (g == 0) ? 0 : 1;
        localparam int unsigned CW  = (g == 0) ? 16 : 4;

        logic          rst_n    = 1'b1;
        logic [W-1:0]  in_data  = '0;
        logic          in_valid = 1'b0;
        logic          shift_en = 1'b0;
        logic          in_ready;
        logic          ser_out;
        logic          ser_valid;
        logic          frame_start;
        logic          busy;
        logic [CW-1:0] frame_cnt;

        exp_t          q[$];
        int unsigned   exp_cnt = 0;
        bit            mon_en  = 1'b0;
        bit            done    = 1'b0;
        int            en_mode = 0;
        int            en_rate = 100;
        int            vld     = 0;
        int            fs      = 0;

        shift_reg_ctrl #(
            .WIDTH     (W),
            .GAP       (GP),
            .LSB_FIRST (LSB),
            .CNT_W     (CW)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_data     (in_data),
            .in_valid    (in_valid),
            .in_ready    (in_ready),
            .shift_en    (shift_en),
            .ser_out     (ser_out),
            .ser_valid   (ser_valid),
            .frame_start (frame_start),
            .busy        (busy),
            .frame_cnt   (frame_cnt)
        );

        task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
            check($sformatf("cfg%0d_%s", G, n), a, e);
        endtask

        task automatic cycles(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        // Present a word, wait for the handshake, record its bits in order.
        task automatic send(input logic [W-1:0] w, input bit hold, input bit chk_len);
            int n;
            in_data  = w;
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("accept_wait", 32'(in_ready), 32'd1);
            @(posedge clk);
            for (int i = 0; i < int'(W); i++) begin
                exp_t e;
                int   idx;
                idx     = (LSB != 0) ? i : int'(W) - 1 - i;
                e.b     = w[idx];
                e.first = (i == 0);
                e.last  = (i == int'(W) - 1);
                q.push_back(e);
            end
            #1;
            if (!hold) in_valid = 1'b0;
            if (chk_len) begin
                n = 0;
                @(negedge clk);
                while (!in_ready && n < 500) begin
                    n++;
                    @(negedge clk);
                end
                chk("ready_low_cycles", 32'(n), 32'(W + GP));
            end
        endtask

        task automatic drain();
            int n;
            n = 0;
            while ((q.size() != 0 || !in_ready) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("drain_done", 32'(q.size() == 0 && in_ready), 32'd1);
        endtask

        task automatic do_reset(input bit hold_valid);
            mon_en   = 1'b0;
            in_valid = hold_valid;
            in_data  = W'($urandom);
            rst_n    = 1'b0;
            #1;
            chk("rst_ser_out", 32'(ser_out), 32'd0);
            chk("rst_ser_valid", 32'(ser_valid), 32'd0);
            chk("rst_frame_start", 32'(frame_start), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            q.delete();
            exp_cnt = 0;
            cycles(2);
            chk("rst_no_capture", 32'(ser_valid), 32'd0);
            in_valid = 1'b0;
            #1;
            rst_n = 1'b1;
            cycles(1);
            chk("post_rst_in_ready", 32'(in_ready), 32'd1);
            chk("post_rst_busy", 32'(busy), 32'd0);
            mon_en = 1'b1;
        endtask

        // Bit-rate enable: 0 = always, 2 = random duty, 3 = driven by the test.
        initial forever begin
            @(posedge clk);
            #1;
            if (en_mode == 0) shift_en = 1'b1;
            else if (en_mode == 2) shift_en = ($urandom_range(99) < en_rate);
        end

        // Monitor: compares every cycle against the scoreboard head.
        initial forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("frame_cnt", 32'(frame_cnt), exp_cnt);
                chk("busy", 32'(busy), 32'(!in_ready));
                chk("ser_valid", 32'(ser_valid), 32'(q.size() != 0));
                if (ser_valid) vld++;
                if (frame_start) fs++;
                if (q.size() != 0) begin
                    chk("ser_out", 32'(ser_out), 32'(q[0].b));
                    chk("frame_start", 32'(frame_start), 32'(q[0].first));
                    if (shift_en) begin
                        exp_t e;
                        e = q.pop_front();
                        if (e.last) exp_cnt = (exp_cnt + 1) % (32'd1 << CW);
                    end
                end else begin
                    chk("idle_ser_out", 32'(ser_out), 32'd0);
                    chk("idle_frame_start", 32'(frame_start), 32'd0);
                end
            end
        end

        if (g == 0) begin : g_main
            initial begin
                #2;
                do_reset(1'b1);
                en_mode = 0;
                vld = 0;
                fs = 0;
                send(8'h0F, 1'b0, 1'b1);
                drain();
                chk("t1_valid_cycles", 32'(vld), 32'd8);
                chk("t1_start_cycles", 32'(fs), 32'd1);
                chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);

                en_mode = 3;
                cycles(1);
                shift_en = 1'b0;
                vld = 0;
                fs = 0;
                send(8'hA5, 1'b0, 1'b0);
                for (int b = 0; b < int'(W); b++) begin
                    cycles(3);
                    shift_en = 1'b1;
                    cycles(1);
                    shift_en = 1'b0;
                end
                drain();
                chk("t3_valid_cycles", 32'(vld), 32'd32);
                chk("t3_start_cycles", 32'(fs), 32'd4);
                chk("t3_frame_cnt", 32'(frame_cnt), 32'd2);

                en_mode = 2;
                for (int i = 0; i < 20; i++) begin
                    en_rate = $urandom_range(100, 20);
                    cycles($urandom_range(3));
                    send(W'($urandom), 1'b0, 1'b0);
                end
                drain();
                chk("rand_frame_cnt", 32'(frame_cnt), 32'd22);

                en_mode = 0;
                cycles(1);
                send(8'hFF, 1'b0, 1'b0);
                repeat (3) @(posedge clk);
                #3;
                do_reset(1'b0);
                send(W'($urandom), 1'b0, 1'b1);
                send(W'($urandom), 1'b0, 1'b1);
                drain();
                chk("post_abort_frame_cnt", 32'(frame_cnt), 32'd2);
                done = 1'b1;
            end
        end else begin : g_main
            initial begin
                #2;
                do_reset(1'b0);
                en_mode = 0;
                send(8'h12, 1'b1, 1'b1);
                send(8'h34, 1'b0, 1'b1);
                drain();
                chk("t4_frame_cnt", 32'(frame_cnt), 32'd2);
                send(8'h0F, 1'b0, 1'b1);
                drain();
                chk("t2_frame_cnt", 32'(frame_cnt), 32'd3);

                do_reset(1'b0);
                en_mode = 2;
                for (int i = 1; i <= 17; i++) begin
                    en_rate = $urandom_range(100, 30);
                    cycles($urandom_range(2));
                    send(W'($urandom), 1'b0, 1'b0);
                    if (i == 15) begin
                        drain();
                        chk("t6_cnt15", 32'(frame_cnt), 32'd15);
                    end else if (i == 16) begin
                        drain();
                        chk("t6_wrap0", 32'(frame_cnt), 32'd0);
                    end
                end
                drain();
                chk("t6_cnt_after_wrap", 32'(frame_cnt), 32'd1);
                done = 1'b1;
            end
        end
    end

    initial begin
        fork
            wait (g_cfg[0].done && g_cfg[1].done);
            #1_000_000;
        join_any
        check("all_done", 32'(g_cfg[0].done && g_cfg[1].done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
- Controller that sequences a parallel-in/serial-out shift register.
- Accepts a parallel word over a valid/ready handshake and serialises it one bit per enabled cycle, MSB-first or LSB-first.
- Inserts a programmable inter-frame gap and counts completed frames.
- Sits between a word-producing block and any serial consumer in the shift-register family of designs.

Parameters:
WIDTH, 8, bits per frame (>=2)
GAP, 2, idle clock cycles after each frame before a new word is accepted (0 allowed)
LSB_FIRST, 0, 0 = MSB shifted out first, 1 = LSB first
CNT_W, 16, width of frame counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  parallel word to serialise
in_valid  input  1  in_data valid
in_ready  output  1  controller can accept a word
shift_en  input  1  bit-rate enable; a bit advances only on cycles where it is high
ser_out  output  1  serial data bit
ser_valid  output  1  ser_out carries a frame bit
frame_start  output  1  high while the first bit of a frame is on ser_out
busy  output  1  state != IDLE
frame_cnt  output  CNT_W  completed frames, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, named rst_n.
- Reset (async, immediate, including mid-frame):
  - state=IDLE; shift register, bit_cnt, gap_cnt and frame_cnt all cleared.
  - ser_out=0, ser_valid=0, frame_start=0, busy=0.
  - in_ready=1 from the first edge after rst_n deasserts.
- States:
  - IDLE -> SHIFT on in_valid && in_ready. Word is loaded at that edge; bit_cnt=0.
  - SHIFT -> GAP, or SHIFT -> IDLE if GAP==0, on shift_en && bit_cnt==WIDTH-1. frame_cnt increments at the same edge.
  - GAP -> IDLE after exactly GAP clock cycles. The gap counts clock cycles, not shift_en cycles.
- Handshake:
  - in_ready = (state==IDLE), no combinational path from in_valid.
  - in_valid while not ready is ignored and the data is not captured. The producer holds it until accepted.
  - Minimum spacing between accepts is WIDTH+GAP+1 cycles at shift_en=1, because IDLE always lasts at least one cycle.
- Latency: word accepted at edge k; first bit on ser_out from edge k to edge k+1. shift_en is not required for the first bit to appear.
- Serial output:
  - ser_out is the register output: shreg[WIDTH-1] (MSB-first) or shreg[0] (LSB-first). Outside SHIFT it is forced to 0.
  - ser_valid = (state==SHIFT).
  - frame_start = (state==SHIFT && bit_cnt==0).
  - Each bit is held until an edge with shift_en=1, then the register shifts by one toward the output end and bit_cnt increments.
- shift_en is ignored in IDLE and GAP.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- bit_cnt width = clog2(WIDTH); gap_cnt width = clog2(GAP+1).
- in_valid and rst_n asserted simultaneously: reset wins and nothing is captured.

Decomposition:
- Shared package/include shift_ctrl_pkg:
  - state encodings (S_IDLE, S_SHIFT, S_GAP);
  - direction constants (DIR_MSB, DIR_LSB).
- Sub-module piso_shift_reg:
  - parameterised by WIDTH and LSB_FIRST;
  - ports clk, rst_n, load, shift, d[WIDTH], q;
  - load has priority over shift.
- The controller holds the FSM, counters and handshake.

Test Plan:
1. WIDTH=8, GAP=2, shift_en=1, send 0x0F -> ser_out 0,0,0,0,1,1,1,1 over 8 cycles; ser_valid high 8 cycles; frame_start high 1 cycle; in_ready low 10 cycles; frame_cnt=1.
2. Same config with LSB_FIRST=1, send 0x0F -> ser_out 1,1,1,1,0,0,0,0.
3. shift_en high 1 cycle in 4, send 0xA5 -> each bit held 4 cycles (32 cycles of ser_valid); bit pattern 1,0,1,0,0,1,0,1.
4. in_valid held high with 0x12 then 0x34 back-to-back, GAP=0 -> 0x12 accepted, 0x34 accepted at the first IDLE cycle (9 cycles later); no word lost or duplicated; frame_cnt=2.
5. Assert rst_n=0 asynchronously after bit 3 of 0xFF -> ser_out, ser_valid and busy drop to 0 without waiting for a clock; frame_cnt stays 0; in_ready=1 after release.
6. CNT_W=4, 16 frames -> frame_cnt counts 1..15 then wraps to 0; the 17th frame gives 1.
